// File: rtl/lms_frame_pkg.sv
// Shared types and constants for the LMS frame packer.
package lms_frame_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_FRAME_LEN = 256;
  localparam int DEF_FCNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    PAD   = 2'd3
  } state_e;

  // A two-sample frame still needs one index bit.
  function automatic int idx_width(input int frame_len);
    return (frame_len <= 2) ? 1 : $clog2(frame_len);
  endfunction

endpackage

// File: rtl/lms_frame_out_reg.sv
// One-entry registered output slot: captures on load, empties on accept.
module lms_frame_out_reg #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic [IDX_W-1:0]  ld_idx_i,
  input  logic              ld_last_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              last_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;

  // A load in the same cycle as an accept replaces the sample with no bubble.
  always_comb begin
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = ld_data_i;
      idx_d   = ld_idx_i;
      last_d  = ld_last_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign idx_o   = idx_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/lms_frame_packer.sv
// Pops samples from the prefetch FIFO and emits indexed fixed-length frames.
// Optional zero-padding flush is enabled by defining LMS_FRAME_PAD_EN.
module lms_frame_packer
  import lms_frame_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int IDX_W     = idx_width(FRAME_LEN),
  parameter int FCNT_W    = DEF_FCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
`ifdef LMS_FRAME_PAD_EN
  input  logic              flush,
`endif
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_vld,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic [IDX_W-1:0]  m_idx,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              done_q, done_d;

  logic              out_room;
  logic              pop;
  logic              pad_load;
  logic              load;
  logic              accept;
  logic              at_last;
  logic              flush_req;
  logic [DATA_W-1:0] ld_data;

`ifdef LMS_FRAME_PAD_EN
  assign flush_req = flush;
  assign pad_load  = (state_q == PAD) & (idx_q != '0) & out_room;
`else
  assign flush_req = 1'b0;
  assign pad_load  = 1'b0;
`endif

  assign out_room   = ~m_valid | m_ready;
  assign fifo_rd_en = (state_q == RUN) & out_room;
  assign pop        = fifo_rd_vld & fifo_rd_en;
  assign load       = pop | pad_load;
  assign ld_data    = pad_load ? '0 : fifo_rd_data;
  assign at_last    = (idx_q == LAST_IDX);
  assign accept     = m_valid & m_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (load) begin
      idx_d = at_last ? '0 : idx_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (en) state_d = RUN;
      end
      RUN: begin
        // A frame that has started always runs to completion, even with en low.
        if (pop) begin
          if (at_last)                          state_d = en ? RUN : DRAIN;
          else if (flush_req && idx_q != '0)    state_d = PAD;
        end else if (flush_req && idx_q != '0) begin
          state_d = PAD;
        end else if (!en && idx_q == '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        idx_d = '0;
        if (accept || !m_valid) state_d = IDLE;
      end
`ifdef LMS_FRAME_PAD_EN
      PAD: begin
        // Index back at zero means the padded m_last is loaded; wait for its accept.
        if (idx_q == '0 && accept) state_d = en ? RUN : DRAIN;
      end
`endif
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    done_d = accept & m_last;
    fcnt_d = fcnt_q;
    if (accept && m_last) fcnt_d = fcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      fcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      done_q  <= done_d;
    end
  end

  lms_frame_out_reg #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .ld_data_i (ld_data),
    .ld_idx_i  (idx_q),
    .ld_last_i (at_last),
    .ready_i   (m_ready),
    .data_o    (m_data),
    .idx_o     (m_idx),
    .last_o    (m_last),
    .valid_o   (m_valid)
  );

  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;
  assign busy       = ((state_q == RUN) | (state_q == PAD)) & ((idx_q != '0) | m_valid);

endmodule

// File: doc/lms_frame_packer.md
Name: lms_frame_packer

Overview:
- Consumer stage directly downstream of the LMS sample prefetch FIFO.
- Pops audio samples over the FIFO's rd_en/rd_vld interface.
- Groups the samples into fixed-length frames with a per-sample index and an end-of-frame flag.
- Presents each frame on a registered valid/ready master port that feeds the LMS/FFT datapath; a downstream stall holds the FIFO rather than dropping samples.

Parameters:
- DATA_W, 16, sample width in bits (must equal the FIFO read data width).
- FRAME_LEN, 256, samples per frame; legal range 2..4096.
- IDX_W, $clog2(FRAME_LEN), width of the sample index (derived; do not override).
- FCNT_W, 16, width of the wrapping frame counter.

Ports:
- clk  in  1  single clock, shared with the FIFO read side.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  level; 1 = start and continue framing.
- fifo_rd_data  in  DATA_W  sample from the FIFO.
- fifo_rd_vld  in  1  FIFO output holds a valid sample.
- fifo_rd_en  out  1  pop request; a sample is popped when fifo_rd_vld & fifo_rd_en.
- m_data  out  DATA_W  output sample.
- m_idx  out  IDX_W  position of the sample within its frame.
- m_last  out  1  marks the sample at index FRAME_LEN-1.
- m_valid  out  1  output holds a valid sample.
- m_ready  in  1  downstream accepts the sample.
- frame_done  out  1  one-cycle pulse when the last sample of a frame is accepted.
- frame_cnt  out  FCNT_W  number of completed frames; wraps at 2^FCNT_W.
- busy  out  1  high while a frame is open.

Behaviour:
- Reset values: all outputs 0, state IDLE, index counter 0.
- Output stage: single register. load = fifo_rd_vld & fifo_rd_en.
  - On load: m_data, m_idx and m_last update, and m_valid is set.
  - m_valid clears on m_valid & m_ready without a simultaneous load.
  - Latency from pop to m_valid is 1 cycle.
- fifo_rd_en = (state==RUN) & (~m_valid | m_ready). This allows a sample every cycle under continuous ready.
- Stability: m_data, m_idx and m_last must hold stable while m_valid & ~m_ready.
- State machine:
  - IDLE -> RUN when en=1. The index counter is 0 on entry.
  - RUN: each load increments the index.
  - At the load of index FRAME_LEN-1, the index wraps to 0.
  - If en=0 at that cycle, go to DRAIN; otherwise stay in RUN.
  - Deasserting en mid-frame never truncates the frame. The frame completes, then the block stops.
  - DRAIN -> IDLE when the held output is accepted (m_valid & m_ready) or m_valid is already 0. No pops occur in DRAIN.
- Frame accounting:
  - frame_done pulses in the cycle after the accept of m_last.
  - frame_cnt increments in that same cycle.
- busy = (state==RUN) & (index!=0 | m_valid).
- FIFO empty (fifo_rd_vld=0): the index holds and the block does not time out. m_valid drops once the held sample is accepted.
- Simultaneous accept and load: the new sample replaces the old one with m_valid staying 1 and no bubble.
- Reset mid-frame: the partial frame is discarded, the index returns to 0 and frame_cnt clears. No samples are popped until reset releases and en is 1.

Optional Feature:
- Macro: LMS_FRAME_PAD_EN.
- With the macro defined:
  - An extra input flush (1 bit) is added.
  - flush=1 in RUN with index!=0 enters state PAD.
  - PAD stops popping and emits zero samples with continuing indices until m_last is accepted, then goes to DRAIN (en=0) or RUN.
  - A flush with index==0 is ignored.
  - frame_done and frame_cnt behave as for a normal frame.
- Without the macro: no flush port, no PAD state. A partial frame remains open until samples arrive.

Decomposition:
- Package lms_frame_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, PAD);
  - the default FRAME_LEN and DATA_W constants;
  - the function that computes the index width.
- Natural sub-module: lms_frame_out_reg, the one-entry output register with its load/accept logic. The FSM and counters stay in the top level.

Test Plan:
- Continuous stream: FRAME_LEN=8, en=1, FIFO always valid, m_ready=1.
  - Required: 8 samples per frame, one per cycle, with idx 0..7.
  - m_last is 1 only at idx 7, and frame_done pulses once per 8 accepts.
  - After 3 frames, frame_cnt=3.
- Backpressure: m_ready toggles 1010.
  - Required: m_data is stable during stalls, and no sample is lost or duplicated.
  - The output sequence equals the FIFO input sequence (ramp 0..23).
- FIFO underflow: fifo_rd_vld=0 for 5 cycles at idx 3.
  - Required: m_valid=0 after the accept, the index resumes at 4 and busy stays 1.
- en drop mid-frame: en=0 at idx 2.
  - Required: the frame completes through idx 7, then DRAIN, then IDLE.
  - fifo_rd_en stays 0 afterwards and frame_cnt increments once.
- Async reset at idx 5.
  - Required: all outputs are 0 immediately.
  - After release with en=1, the next sample carries idx 0.
- (LMS_FRAME_PAD_EN) flush at idx 5, FRAME_LEN=8.
  - Required: idx 5..7 are output with m_data=0, m_last at idx 7, and frame_done pulses.
  - No FIFO pops occur during PAD.
